arith_operand_join: RTL and testbench

ARITH_OPERAND_JOIN -- requirements
Module: arith_operand_join

---
 rtl/arith_pkg.sv | 9 +
 rtl/arith_fifo.sv | 66 ++++++
 rtl/arith_operand_join.sv | 65 ++++++
 tb/tb_arith_operand_join.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arith datapath blocks (operand join, FIFOs).
package arith_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/arith_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count; storage is not reset.
module arith_fifo
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data_c,
  output logic [occ_width(DEPTH)-1:0]   count,
  output logic                          full_c,
  output logic                          empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = occ_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arith_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data_c = mem_q[rd_ptr_q];
  assign count       = cnt_q;
  assign full_c      = (cnt_q == CNT_W'(DEPTH));
  assign empty_c     = (cnt_q == '0);

endmodule

// File: rtl/arith_operand_join.sv
// Joins independently produced A/B operands into aligned pairs for the FP divider.
module arith_operand_join
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [WIDTH-1:0]             a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [WIDTH-1:0]             b_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_a_data,
  output logic [WIDTH-1:0]             out_b_data,
  output logic [occ_width(DEPTH)-1:0]  a_count,
  output logic [occ_width(DEPTH)-1:0]  b_count
);

  logic a_full_c, a_empty_c, b_full_c, b_empty_c;
  logic a_push_c, b_push_c, pop_c;

  // Readiness depends only on local occupancy, never on the consumer.
  assign a_ready   = !rst && !a_full_c;
  assign b_ready   = !rst && !b_full_c;
  assign a_push_c  = a_valid && a_ready;
  assign b_push_c  = b_valid && b_ready;
  assign out_valid = !rst && !a_empty_c && !b_empty_c;
  assign pop_c     = out_valid && out_ready;

  arith_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_a_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (a_push_c),
    .push_data   (a_data),
    .pop         (pop_c),
    .head_data_c (out_a_data),
    .count       (a_count),
    .full_c      (a_full_c),
    .empty_c     (a_empty_c)
  );

  arith_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_b_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (b_push_c),
    .push_data   (b_data),
    .pop         (pop_c),
    .head_data_c (out_b_data),
    .count       (b_count),
    .full_c      (b_full_c),
    .empty_c     (b_empty_c)
  );

endmodule

// File: tb/tb_arith_operand_join.sv
// Randomized/directed bench for arith_operand_join against a queue-based pairing model.
module tb_arith_operand_join;

  logic clk;
  logic rst;

  logic        a_valid0, a_ready0, b_valid0, b_ready0, out_valid0, out_ready0;
  logic [31:0] a_data0, b_data0, out_a0, out_b0;
  logic [1:0]  a_count0, b_count0;

  logic        a_valid1, a_ready1, b_valid1, b_ready1, out_valid1, out_ready1;
  logic [63:0] a_data1, b_data1, out_a1, out_b1;
  logic [2:0]  a_count1, b_count1;

  arith_operand_join u_dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid0), .a_ready(a_ready0), .a_data(a_data0),
    .b_valid(b_valid0), .b_ready(b_ready0), .b_data(b_data0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_a_data(out_a0), .out_b_data(out_b0),
    .a_count(a_count0), .b_count(b_count0)
  );

  arith_operand_join #(.WIDTH(64), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data1),
    .b_valid(b_valid1), .b_ready(b_ready1), .b_data(b_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_a_data(out_a1), .out_b_data(out_b1),
    .a_count(a_count1), .b_count(b_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: accepted-but-unpaired operands per side, plus producer backlogs.
  logic [63:0] qa[$], qb[$], srca[$], srcb[$];
  int sel, depth;
  int checks, failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd();
    if (sel == 1) return {$urandom, $urandom};
    return {32'h0, $urandom};
  endfunction

  // One clock cycle: drive producers/consumer, compare against model, advance model.
  task automatic step(input bit ga, input bit gb, input bit ordy);
    logic        va, vb, exp_ar, exp_br, exp_ov, acc_a, acc_b, pop;
    logic [63:0] da, db, o_ar, o_br, o_ov, o_ac, o_bc, o_a, o_b;
    va = ga && (srca.size() > 0);
    vb = gb && (srcb.size() > 0);
    da = va ? srca[0] : 64'h0;
    db = vb ? srcb[0] : 64'h0;
    if (sel == 0) begin
      a_valid0 = va; a_data0 = da[31:0]; b_valid0 = vb; b_data0 = db[31:0]; out_ready0 = ordy;
      a_valid1 = 1'b0; b_valid1 = 1'b0; out_ready1 = 1'b0;
    end else begin
      a_valid1 = va; a_data1 = da; b_valid1 = vb; b_data1 = db; out_ready1 = ordy;
      a_valid0 = 1'b0; b_valid0 = 1'b0; out_ready0 = 1'b0;
    end
    #1;
    if (sel == 0) begin
      o_ar = 64'(a_ready0); o_br = 64'(b_ready0); o_ov = 64'(out_valid0);
      o_ac = 64'(a_count0); o_bc = 64'(b_count0); o_a = 64'(out_a0); o_b = 64'(out_b0);
    end else begin
      o_ar = 64'(a_ready1); o_br = 64'(b_ready1); o_ov = 64'(out_valid1);
      o_ac = 64'(a_count1); o_bc = 64'(b_count1); o_a = out_a1; o_b = out_b1;
    end
    exp_ar = !rst && (qa.size() < depth);
    exp_br = !rst && (qb.size() < depth);
    exp_ov = !rst && (qa.size() > 0) && (qb.size() > 0);
    chk("a_ready", o_ar, 64'(exp_ar));
    chk("b_ready", o_br, 64'(exp_br));
    chk("out_valid", o_ov, 64'(exp_ov));
    chk("a_count", o_ac, 64'(qa.size()));
    chk("b_count", o_bc, 64'(qb.size()));
    if (exp_ov) begin
      chk("out_a_data", o_a, qa[0]);
      chk("out_b_data", o_b, qb[0]);
    end
    acc_a = va && exp_ar;
    acc_b = vb && exp_br;
    pop   = exp_ov && ordy;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc_a) qa.push_back(srca.pop_front());
      if (acc_b) qb.push_back(srcb.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 2) == 0 && srca.size() < 6) srca.push_back(rnd());
      if ($urandom_range(0, 2) == 0 && srcb.size() < 6) srcb.push_back(rnd());
      rst = ($urandom_range(0, 39) == 0);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    sel = 0; depth = 2;
    rst = 1'b1;
    a_valid0 = 0; b_valid0 = 0; out_ready0 = 0; a_data0 = '0; b_data0 = '0;
    a_valid1 = 0; b_valid1 = 0; out_ready1 = 0; a_data1 = '0; b_data1 = '0;
    @(negedge clk);
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;

    // A in cycle 0, B in cycle 3: pair visible after the cycle-3 edge.
    srca.push_back(64'h3F80_0000);
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    srcb.push_back(64'h4000_0000);
    step(0, 1, 1);
    chk("pair_valid_after_b", 64'(out_valid0), 64'h1);
    chk("pair_a_value", 64'(out_a0), 64'h3F80_0000);
    chk("pair_b_value", 64'(out_b0), 64'h4000_0000);
    step(0, 0, 0);
    step(0, 0, 1);

    // Backpressure: third A value must wait at the producer.
    for (int i = 0; i < 3; i++) srca.push_back(rnd());
    repeat (4) step(1, 1, 0);
    chk("a_full_holds_third", 64'(srca.size()), 64'd1);
    for (int i = 0; i < 3; i++) srcb.push_back(rnd());
    repeat (8) step(1, 1, 1);

    // Streaming with both sides full.
    for (int i = 0; i < 10; i++) begin srca.push_back(rnd()); srcb.push_back(rnd()); end
    repeat (3) step(1, 1, 0);
    repeat (14) step(1, 1, 1);

    // Five A then five B with random consumer stalls.
    for (int i = 0; i < 5; i++) srca.push_back(rnd());
    for (int i = 0; i < 5; i++) srcb.push_back(rnd());
    repeat (6) step(1, 0, 1'($urandom_range(0, 1)));
    repeat (30) step(1, 1, 1'($urandom_range(0, 1)));
    chk("five_pairs_a_drained", 64'(srca.size() + qa.size()), 64'd0);

    // Reset with a_count=2, b_count=1.
    srca.push_back(rnd()); srca.push_back(rnd()); srcb.push_back(rnd());
    repeat (3) step(1, 1, 0);
    rst = 1'b1;
    step(1, 1, 1);
    rst = 1'b0;
    step(1, 1, 1);
    step(1, 1, 1);

    random_phase(300);
    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    srca.delete(); srcb.delete();

    // 64-bit / depth-4 instance.
    sel = 1; depth = 4;
    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    srca.push_back(64'h3FF0_0000_0000_0000);
    for (int i = 0; i < 4; i++) srca.push_back(rnd());
    repeat (6) step(1, 0, 0);
    chk("wide_a_count_full", 64'(a_count1), 64'd4);
    srcb.push_back(64'h4000_0000_0000_0000);
    for (int i = 0; i < 4; i++) srcb.push_back(rnd());
    step(0, 1, 0);
    chk("wide_pair_a", out_a1, 64'h3FF0_0000_0000_0000);
    chk("wide_pair_b", out_b1, 64'h4000_0000_0000_0000);
    repeat (15) step(1, 1, 1);
    random_phase(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
